// File: rtl/xlr8_board_pkg.sv
// rtl/xlr8_board_pkg.sv - register map, I2C target states and default target address
package xlr8_board_pkg;

  localparam logic [6:0] DEF_I2C_ADDR = 7'h2A;

  localparam logic [7:0] REG_GPIOR0      = 8'h00;
  localparam logic [7:0] REG_DDR_D_LO    = 8'h01;
  localparam logic [7:0] REG_DDR_D_HI    = 8'h02;
  localparam logic [7:0] REG_PORT_D_LO   = 8'h03;
  localparam logic [7:0] REG_PORT_D_HI   = 8'h04;
  localparam logic [7:0] REG_PIN_D_LO    = 8'h05;
  localparam logic [7:0] REG_PIN_D_HI    = 8'h06;
  localparam logic [7:0] REG_DDR_A       = 8'h07;
  localparam logic [7:0] REG_PORT_A      = 8'h08;
  localparam logic [7:0] REG_PIN_A       = 8'h09;
  localparam logic [7:0] REG_CONFIG      = 8'h0A;
  localparam logic [7:0] REG_BOOT_STATUS = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_ACK_R
  } i2c_state_e;

endpackage

// File: rtl/xlr8_board_lite_if.sv
// rtl/xlr8_board_lite_if.sv - register bus between the I2C target and the board register file
interface xlr8_board_lite_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/xlr8_board_lite_i2c_target.sv
// rtl/xlr8_board_lite_i2c_target.sv - I2C target: pad sync, START/STOP detect, byte FSM
// Register pointer lives here; rdata is only sampled in the cycle re is high.
module xlr8_i2c_target
  import xlr8_board_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = DEF_I2C_ADDR
) (
  input  logic clk,
  input  logic rst,
  input  logic boot_done,
  input  logic sda,
  input  logic scl,
  output logic sda_oe,
  xlr8_board_lite_if.master bus
);

  logic [2:0] sda_sync, scl_sync;
  logic       sda_s, sda_p, scl_s, scl_p;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sync <= '1;
      scl_sync <= '1;
    end else begin
      sda_sync <= {sda_sync[1:0], sda};
      scl_sync <= {scl_sync[1:0], scl};
    end
  end

  assign sda_s     = sda_sync[1];
  assign sda_p     = sda_sync[2];
  assign scl_s     = scl_sync[1];
  assign scl_p     = scl_sync[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  i2c_state_e state, state_nxt;
  logic [7:0] shreg, shreg_nxt, ptr, ptr_nxt;
  logic [2:0] bit_cnt, cnt_nxt;
  logic       rw, rw_nxt, ack_phase, phase_nxt, ptr_loaded, loaded_nxt;
  logic       mack, mack_nxt, oe_nxt, we_c, load_rd;

  // Kept outside the FSM block so the rdata path has no apparent feedback.
  assign load_rd = boot_done && !start_det && !stop_det && scl_fall &&
                   ((state == ST_ACK_ADDR && ack_phase && rw) || (state == ST_ACK_R && mack));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= 8'h00;
      ptr        <= 8'h00;
      bit_cnt    <= 3'd0;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      ptr_loaded <= 1'b0;
      mack       <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      ptr        <= ptr_nxt;
      bit_cnt    <= cnt_nxt;
      rw         <= rw_nxt;
      ack_phase  <= phase_nxt;
      ptr_loaded <= loaded_nxt;
      mack       <= mack_nxt;
      sda_oe     <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    ptr_nxt    = ptr;
    cnt_nxt    = bit_cnt;
    rw_nxt     = rw;
    phase_nxt  = ack_phase;
    loaded_nxt = ptr_loaded;
    mack_nxt   = mack;
    oe_nxt     = sda_oe;
    we_c       = 1'b0;
    if (!boot_done) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt = ST_ADDR;
      cnt_nxt   = 3'd0;
      oe_nxt    = 1'b0;
    end else if (stop_det) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shreg_nxt = {shreg[6:0], sda_s};
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rw_nxt    = sda_s;
            phase_nxt = 1'b0;
            state_nxt = (shreg[6:0] == I2C_ADDR) ? ST_ACK_ADDR : ST_IDLE;
          end
        end
        ST_ACK_ADDR: if (scl_fall) begin
          if (!ack_phase) begin
            phase_nxt = 1'b1;
            oe_nxt    = 1'b1;
          end else if (rw) begin
            shreg_nxt = bus.rdata;
            oe_nxt    = ~bus.rdata[7];
            ptr_nxt   = ptr + 8'd1;
            cnt_nxt   = 3'd0;
            mack_nxt  = 1'b0;
            state_nxt = ST_RDATA;
          end else begin
            oe_nxt     = 1'b0;
            cnt_nxt    = 3'd0;
            loaded_nxt = 1'b0;
            state_nxt  = ST_WDATA;
          end
        end
        ST_WDATA: if (scl_rise) begin
          shreg_nxt = {shreg[6:0], sda_s};
          cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            phase_nxt = 1'b0;
            state_nxt = ST_ACK_W;
          end
        end
        ST_ACK_W: if (scl_fall) begin
          if (!ack_phase) begin
            phase_nxt = 1'b1;
            oe_nxt    = 1'b1;
            if (!ptr_loaded) begin
              ptr_nxt    = shreg;
              loaded_nxt = 1'b1;
            end else begin
              we_c    = 1'b1;
              ptr_nxt = ptr + 8'd1;
            end
          end else begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 3'd0;
            state_nxt = ST_WDATA;
          end
        end
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            oe_nxt    = 1'b0;
            state_nxt = ST_ACK_R;
          end else begin
            shreg_nxt = {shreg[6:0], 1'b0};
            oe_nxt    = ~shreg[6];
            cnt_nxt   = bit_cnt + 3'd1;
          end
        end
        ST_ACK_R: begin
          if (scl_rise) mack_nxt = ~sda_s;
          if (scl_fall) begin
            if (mack) begin
              shreg_nxt = bus.rdata;
              oe_nxt    = ~bus.rdata[7];
              ptr_nxt   = ptr + 8'd1;
              cnt_nxt   = 3'd0;
              mack_nxt  = 1'b0;
              state_nxt = ST_RDATA;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.addr  = ptr;
  assign bus.wdata = shreg;
  assign bus.we    = we_c;
  assign bus.re    = load_rd;

endmodule

// File: rtl/xlr8_board_lite.sv
// rtl/xlr8_board_lite.sv - XLR8 board stand-in: boot delay, register file, GPIO tristates, I2C target
module xlr8_board_lite
  import xlr8_board_pkg::*;
#(
  parameter int         DESIGN_CONFIG = 9,
  parameter logic [6:0] I2C_ADDR      = DEF_I2C_ADDR,
  parameter int         BOOT_CYCLES   = 64,
  parameter bit         SIM_MODE      = 1'b0
) (
  input  logic        Clock,
  input  logic        RESET,
  inout  wire  [13:0] Digital,
  inout  wire  [5:0]  Ana_Dig,
  inout  wire         SDA,
  inout  wire         SCL
);

  xlr8_board_lite_if bus ();

  logic [15:0] boot_cnt;
  logic        boot_restore_n;
  logic        sda_oe;
  logic [7:0]  gpior0, rdata_c;
  logic [13:0] ddr_d, port_d, pin_d_s1, pin_d;
  logic [5:0]  ddr_a, port_a, pin_a_s1, pin_a;

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) boot_cnt <= 16'd0;
    else if (!boot_restore_n) boot_cnt <= boot_cnt + 16'd1;
  end

  assign boot_restore_n = (boot_cnt == 16'(BOOT_CYCLES));

  xlr8_i2c_target #(.I2C_ADDR(I2C_ADDR)) u_i2c (
    .clk       (Clock),
    .rst       (RESET),
    .boot_done (boot_restore_n),
    .sda       (SDA),
    .scl       (SCL),
    .sda_oe    (sda_oe),
    .bus       (bus.master)
  );

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      gpior0 <= {7'b0, SIM_MODE};
      ddr_d  <= '0;
      port_d <= '0;
      ddr_a  <= '0;
      port_a <= '0;
    end else if (bus.we) begin
      case (bus.addr)
        REG_GPIOR0:    gpior0       <= bus.wdata;
        REG_DDR_D_LO:  ddr_d[7:0]   <= bus.wdata;
        REG_DDR_D_HI:  ddr_d[13:8]  <= bus.wdata[5:0];
        REG_PORT_D_LO: port_d[7:0]  <= bus.wdata;
        REG_PORT_D_HI: port_d[13:8] <= bus.wdata[5:0];
        REG_DDR_A:     ddr_a        <= bus.wdata[5:0];
        REG_PORT_A:    port_a       <= bus.wdata[5:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_c = 8'h00;
    if (bus.re) begin
      case (bus.addr)
        REG_GPIOR0:      rdata_c = gpior0;
        REG_DDR_D_LO:    rdata_c = ddr_d[7:0];
        REG_DDR_D_HI:    rdata_c = {2'b00, ddr_d[13:8]};
        REG_PORT_D_LO:   rdata_c = port_d[7:0];
        REG_PORT_D_HI:   rdata_c = {2'b00, port_d[13:8]};
        REG_PIN_D_LO:    rdata_c = pin_d[7:0];
        REG_PIN_D_HI:    rdata_c = {2'b00, pin_d[13:8]};
        REG_DDR_A:       rdata_c = {2'b00, ddr_a};
        REG_PORT_A:      rdata_c = {2'b00, port_a};
        REG_PIN_A:       rdata_c = {2'b00, pin_a};
        REG_CONFIG:      rdata_c = 8'(DESIGN_CONFIG);
        REG_BOOT_STATUS: rdata_c = {7'b0, boot_restore_n};
        default:         rdata_c = 8'h00;
      endcase
    end
  end

  assign bus.rdata = rdata_c;

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      pin_d_s1 <= '0;
      pin_d    <= '0;
      pin_a_s1 <= '0;
      pin_a    <= '0;
    end else begin
      pin_d_s1 <= Digital;
      pin_d    <= pin_d_s1;
      pin_a_s1 <= Ana_Dig;
      pin_a    <= pin_a_s1;
    end
  end

  // Pins stay released until the boot restore window has elapsed.
  for (genvar i = 0; i < 14; i++) begin : g_dig
    assign Digital[i] = (ddr_d[i] && boot_restore_n) ? port_d[i] : 1'bz;
  end

  for (genvar i = 0; i < 6; i++) begin : g_ana
    assign Ana_Dig[i] = (ddr_a[i] && boot_restore_n) ? port_a[i] : 1'bz;
  end

  assign SDA = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_xlr8_board_lite.sv
// tb/tb_xlr8_board_lite.sv - directed I2C/GPIO bench for xlr8_board_lite
module tb_xlr8_board_lite;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sda_rel = 1'b1;
  logic        scl_r = 1'b1;
  logic        ana_en = 1'b0;
  logic [5:0]  ana_val = 6'h00;
  wire  [13:0] digital;
  wire  [5:0]  ana;
  wire         sda;
  wire         scl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign sda = sda_rel ? 1'bz : 1'b0;
  assign scl = scl_r;
  assign ana = ana_en ? ana_val : 6'bzzzzzz;
  pullup (sda);
  pullup (digital);
  pullup (ana);

  xlr8_board_lite #(
    .DESIGN_CONFIG (9),
    .I2C_ADDR      (7'h2A),
    .BOOT_CYCLES   (400),
    .SIM_MODE      (1'b1)
  ) dut (
    .Clock   (clk),
    .RESET   (rst),
    .Digital (digital),
    .Ana_Dig (ana),
    .SDA     (sda),
    .SCL     (scl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start;
    sda_rel = 1'b1; #T;
    scl_r = 1'b1;   #T;
    sda_rel = 1'b0; #T;
    scl_r = 1'b0;   #T;
  endtask

  task automatic i2c_stop;
    sda_rel = 1'b0; #T;
    scl_r = 1'b1;   #T;
    sda_rel = 1'b1; #T;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    sda_rel = b; #T;
    scl_r = 1'b1; #T;
    s = sda;      #T;
    scl_r = 1'b0; #T;
  endtask

  task automatic i2c_wr(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic i2c_rd(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(nack, s);
  endtask

  task automatic write_reg(input logic [7:0] r, input logic [7:0] d);
    logic ack;
    i2c_start;
    i2c_wr(8'h54, ack); check("wr_addr_ack", ack, 1);
    i2c_wr(r, ack);     check("wr_ptr_ack", ack, 1);
    i2c_wr(d, ack);     check("wr_data_ack", ack, 1);
    i2c_stop;
  endtask

  task automatic read_reg(input logic [7:0] r, output logic [7:0] v);
    logic ack;
    i2c_start;
    i2c_wr(8'h54, ack); check("rd_waddr_ack", ack, 1);
    i2c_wr(r, ack);     check("rd_ptr_ack", ack, 1);
    i2c_start;
    i2c_wr(8'h55, ack); check("rd_raddr_ack", ack, 1);
    i2c_rd(1'b1, v);
    i2c_stop;
  endtask

  initial begin
    logic       ack;
    logic [7:0] v, v2;
    logic [7:0] wbytes [5];
    wbytes = '{8'h01, 8'hFF, 8'h3F, 8'h55, 8'h2A};

    // reset and boot window
    #100;
    check("rst_sda", 32'(sda), 1);
    check("rst_digital", 32'(digital), 14'h3FFF);
    check("rst_ana", 32'(ana), 6'h3F);
    rst = 1'b0; #20;
    i2c_start;
    i2c_wr(8'h54, ack); check("boot_nack", ack, 0);
    i2c_stop;
    #4500;
    read_reg(8'h0B, v); check("boot_status", v, 8'h01);
    read_reg(8'h00, v); check("rst_gpior0", v, 8'h01);
    read_reg(8'h01, v); check("rst_ddr_d_lo", v, 8'h00);

    // multi-byte write drives Digital
    i2c_start;
    i2c_wr(8'h54, ack); check("t2_addr_ack", ack, 1);
    for (int i = 0; i < 5; i++) begin
      i2c_wr(wbytes[i], ack);
      check($sformatf("t2_byte%0d_ack", i), ack, 1);
    end
    i2c_stop;
    #200;
    check("t2_digital", 32'(digital), 14'h2A55);

    // pointer write, repeated START, two-byte read
    i2c_start;
    i2c_wr(8'h54, ack); check("t3_waddr_ack", ack, 1);
    i2c_wr(8'h0A, ack); check("t3_ptr_ack", ack, 1);
    i2c_start;
    i2c_wr(8'h55, ack); check("t3_raddr_ack", ack, 1);
    i2c_rd(1'b0, v);    check("t3_config", v, 8'h09);
    i2c_rd(1'b1, v2);   check("t3_boot_status", v2, 8'h01);
    check("t3_sda_released", 32'(sda), 1);
    i2c_stop;

    // input pins through the synchronisers
    write_reg(8'h07, 8'h00);
    ana_en = 1'b1; ana_val = 6'h15;
    #300;
    read_reg(8'h09, v); check("t4_pin_a", v, 8'h15);
    read_reg(8'h05, v); check("t4_pin_d_lo", v, 8'h55);
    read_reg(8'h06, v); check("t4_pin_d_hi", v, 8'h2A);

    // wrong address is ignored; pointer wrap
    write_reg(8'h00, 8'hA5);
    read_reg(8'h00, v); check("t5_gpior0", v, 8'hA5);
    i2c_start;
    i2c_wr(8'h56, ack); check("t5_wrong_addr_nack", ack, 0);
    i2c_wr(8'h03, ack);
    i2c_wr(8'h00, ack);
    i2c_stop;
    read_reg(8'h03, v); check("t5_port_d_lo_kept", v, 8'h55);
    i2c_start;
    i2c_wr(8'h54, ack); check("wrap_waddr_ack", ack, 1);
    i2c_wr(8'hFF, ack); check("wrap_ptr_ack", ack, 1);
    i2c_start;
    i2c_wr(8'h55, ack); check("wrap_raddr_ack", ack, 1);
    i2c_rd(1'b0, v);    check("wrap_reg_ff", v, 8'h00);
    i2c_rd(1'b1, v2);   check("wrap_reg_00", v2, 8'hA5);
    i2c_stop;

    // async reset in the middle of a read
    i2c_start;
    i2c_wr(8'h54, ack); check("t6_waddr_ack", ack, 1);
    i2c_wr(8'h0A, ack); check("t6_ptr_ack", ack, 1);
    i2c_start;
    i2c_wr(8'h55, ack); check("t6_raddr_ack", ack, 1);
    check("t6_sda_driven", 32'(sda), 0);
    rst = 1'b1;
    #1;
    check("t6_sda_released", 32'(sda), 1);
    #20;
    check("t6_digital_z", 32'(digital), 14'h3FFF);
    rst = 1'b0;
    i2c_stop;
    #4500;
    read_reg(8'h00, v); check("t6_gpior0", v, 8'h01);
    read_reg(8'h01, v); check("t6_ddr_d_lo", v, 8'h00);
    read_reg(8'h02, v); check("t6_ddr_d_hi", v, 8'h00);
    read_reg(8'h03, v); check("t6_port_d_lo", v, 8'h00);
    read_reg(8'h04, v); check("t6_port_d_hi", v, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
